// File: rtl/audio_sample_streamer.sv
// Fetches a start..end range of 16-bit samples from an SRAM reader into a FIFO
// and plays them out to the codec at one sample every CLK_DIV cycles.
module audio_sample_streamer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 1042,
    parameter int ADDR_W     = 20
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              play,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic [15:0]       sample_out,
    output logic              sample_strobe,
    output logic              underrun,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE,
        ABORT
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic              exhausted;
    logic              outstanding;
    logic [DIV_W-1:0]  divider;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic accept;
    logic push_en;
    logic pop_en;
    logic streaming;
    logic tick;
    logic flush;
    logic fifo_empty;

    assign streaming  = (state == RUN) || (state == DRAIN);
    assign tick       = streaming && play && (divider == DIV_LAST);
    assign fifo_empty = (fifo_count == '0);
    assign pop_en     = tick && !fifo_empty;
    assign accept     = fetch_req && fetch_ack;
    // Read data arriving in ABORT or IDLE is consumed but never stored.
    assign push_en    = rd_valid && outstanding && (state inside {PRIME, RUN, DRAIN});
    assign flush      = (state == IDLE) || (state == ABORT) || (state_nx == ABORT);

    // Only one request in flight, so count+outstanding bounds FIFO occupancy.
    assign fetch_req  = (state inside {PRIME, RUN}) && !exhausted && !outstanding
                        && ((fifo_count + CNT_W'(outstanding)) < FULL_CNT);
    assign fetch_addr = addr_q;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (play) state_nx = PRIME;
            PRIME: begin
                if (!play)                                  state_nx = ABORT;
                else if ((fifo_count == FULL_CNT) || exhausted) state_nx = RUN;
            end
            RUN: begin
                if (!play)          state_nx = ABORT;
                else if (exhausted) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!play)                                  state_nx = ABORT;
                else if (tick && fifo_empty && !outstanding) state_nx = DONE;
            end
            DONE:  if (!play) state_nx = IDLE;
            ABORT: if (!outstanding) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (reset) begin
            addr_q        <= '0;
            start_q       <= '0;
            end_q         <= '0;
            exhausted     <= 1'b0;
            outstanding   <= 1'b0;
            divider       <= '0;
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;

            if (accept) begin
                outstanding <= 1'b1;
                if ((addr_q == end_q) && loop) begin
                    addr_q <= start_q;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (addr_q == end_q) exhausted <= 1'b1;
                end
            end else if (rd_valid && outstanding) begin
                outstanding <= 1'b0;
            end

            if ((state == IDLE) && play) begin
                start_q   <= start_addr;
                end_q     <= end_addr;
                addr_q    <= start_addr;
                exhausted <= 1'b0;
            end

            if (streaming && play) divider <= (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
            else                   divider <= '0;

            // An empty tick still strobes a silent sample; only RUN reports it as underrun.
            if (tick) begin
                sample_strobe <= 1'b1;
                if (pop_en) begin
                    sample_out <= fifo_mem[rd_ptr];
                end else begin
                    sample_out <= '0;
                    underrun   <= (state == RUN);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: sample storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge Clk) begin
        if (push_en) fifo_mem[wr_ptr] <= rd_data;
    end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer: an SRAM reader model returns addr[15:0]
// two cycles after each accepted fetch, and a scoreboard queue checks every strobe.
module tb_audio_sample_streamer;

    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 4;
    localparam int ADDR_W     = 20;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic              play = 1'b0;
    logic              loop = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic              rd_valid = 1'b0;
    logic [15:0]       rd_data = '0;
    logic [15:0]       sample_out;
    logic              sample_strobe;
    logic              underrun;
    logic              busy;
    logic              done;

    logic              hold_ack = 1'b0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] lat_addr = '0;
    logic [ADDR_W-1:0] acc_log[$];
    logic [15:0]       exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_under  = 0;

    audio_sample_streamer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CLK_DIV   (CLK_DIV),
        .ADDR_W    (ADDR_W)
    ) dut (
        .Clk          (Clk),
        .reset        (reset),
        .play         (play),
        .loop         (loop),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .sample_out   (sample_out),
        .sample_strobe(sample_strobe),
        .underrun     (underrun),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // SRAM reader model: accepts immediately unless held, data = address, two-cycle latency.
    assign fetch_ack = fetch_req && !hold_ack;

    always @(posedge Clk) begin
        if (reset) begin
            pend     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            pend     <= fetch_req && fetch_ack;
            rd_valid <= pend;
            if (fetch_req && fetch_ack) begin
                lat_addr <= fetch_addr;
                acc_log.push_back(fetch_addr);
            end
            if (pend) rd_data <= lat_addr[15:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of observation: every strobe is matched against the scoreboard.
    task automatic observe();
        logic [15:0] e;
        @(negedge Clk);
        if (dut.push_en) check("push into full FIFO", 32'(dut.fifo_count < FIFO_DEPTH), 1);
        if (sample_strobe) begin
            if (underrun) begin
                n_under++;
                check("underrun sample value", 32'(sample_out), 0);
            end else if (exp_q.size() == 0) begin
                check("strobe with empty scoreboard", 32'(sample_strobe), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe sample", 32'(sample_out), 32'(e));
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) observe();
    endtask

    task automatic run_until_empty(input int budget, input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            observe();
            cyc++;
        end
        check({tag, " scoreboard drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((busy || done) && cyc < 100) begin
            observe();
            cyc++;
        end
        check({tag, " returns to idle"}, {30'd0, busy, done}, 0);
    endtask

    task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input logic lp);
        start_addr = s;
        end_addr   = e;
        loop       = lp;
        play       = 1'b1;
    endtask

    initial begin
        int base;
        int n_req;
        logic [ADDR_W-1:0] exp_addr [4];

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset fetch_req", 32'(fetch_req), 0);
        check("reset fetch_addr", 32'(fetch_addr), 0);
        check("reset outputs", {13'd0, sample_out, sample_strobe, underrun, busy}, 0);
        check("reset done", 32'(done), 0);
        reset = 1'b0;
        run_cycles(2);

        // Non-loop 16-sample range: exactly 16 acks, samples in order, then done
        base = acc_log.size();
        for (int i = 16'h10; i <= 16'h1F; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'h0000);
        start_play(20'h00010, 20'h0001F, 1'b0);
        n_under = 0;
        run_until_empty(600, "range16");
        check("range16 done", 32'(done), 1);
        check("range16 busy", 32'(busy), 0);
        check("range16 ack count", 32'(acc_log.size() - base), 16);
        check("range16 underruns", 32'(n_under), 0);
        run_cycles(10);
        check("range16 done held", 32'(done), 1);
        play = 1'b0;
        wait_idle("range16");

        // Loop 0..3: repeating sequence, never done
        for (int i = 0; i < 40; i++) exp_q.push_back(16'(i % 4));
        start_play(20'h00000, 20'h00003, 1'b1);
        n_under = 0;
        run_until_empty(800, "loop");
        check("loop done stays low", 32'(done), 0);
        check("loop busy", 32'(busy), 1);
        check("loop underruns", 32'(n_under), 0);
        play = 1'b0;
        wait_idle("loop");

        // Reset in the middle of RUN
        for (int i = 16'h80; i <= 16'h81; i++) exp_q.push_back(16'(i));
        start_play(20'h00080, 20'h000FF, 1'b0);
        run_until_empty(400, "midrun");
        reset = 1'b1;
        play  = 1'b0;
        @(negedge Clk);
        check("midrun reset fetch_req", 32'(fetch_req), 0);
        check("midrun reset fetch_addr", 32'(fetch_addr), 0);
        check("midrun reset outputs", {13'd0, sample_out, sample_strobe, underrun, busy}, 0);
        check("midrun reset done", 32'(done), 0);
        reset = 1'b0;
        n_req = 0;
        repeat (20) begin
            observe();
            if (fetch_req) n_req++;
        end
        check("midrun no fetch after reset", 32'(n_req), 0);

        // Abort with a request outstanding, then replay from start
        for (int i = 16'h40; i <= 16'h43; i++) exp_q.push_back(16'(i));
        start_play(20'h00040, 20'h0007F, 1'b0);
        run_until_empty(400, "abort pre");
        n_req = 0;
        while (!(fetch_req && fetch_ack) && n_req < 20) begin
            observe();
            n_req++;
        end
        check("abort found accept", 32'(fetch_req && fetch_ack), 1);
        @(posedge Clk);
        #1 play = 1'b0;
        observe();
        observe();
        check("abort fetch_req dropped", 32'(fetch_req), 0);
        check("abort busy", 32'(busy), 1);
        wait_idle("abort");
        base = acc_log.size();
        for (int i = 16'h40; i <= 16'h43; i++) exp_q.push_back(16'(i));
        start_play(20'h00040, 20'h0007F, 1'b0);
        run_until_empty(400, "replay");
        check("replay first fetch addr", 32'(acc_log[base]), 32'h00040);
        play = 1'b0;
        wait_idle("replay");

        // Withheld acks in RUN: underruns of silence, then in-order resume
        for (int i = 16'h200; i <= 16'h27F; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'h0000);
        start_play(20'h00200, 20'h0027F, 1'b0);
        run_cycles(150);
        n_under = 0;
        hold_ack = 1'b1;
        run_cycles(200);
        hold_ack = 1'b0;
        check("stall underruns seen", 32'(n_under >= 25), 1);
        run_until_empty(2000, "stall");
        check("stall done", 32'(done), 1);
        play = 1'b0;
        wait_idle("stall");

        // Range crossing address zero
        exp_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        base = acc_log.size();
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        start_play(20'hFFFFE, 20'h00001, 1'b0);
        run_until_empty(300, "wrap");
        check("wrap ack count", 32'(acc_log.size() - base), 4);
        for (int i = 0; i < 4; i++)
            if (base + i < acc_log.size()) check("wrap fetch addr", 32'(acc_log[base + i]), 32'(exp_addr[i]));
        check("wrap done", 32'(done), 1);
        play = 1'b0;
        wait_idle("wrap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
